// File: rtl/util_puf_emulator.sv
// Deterministic PUF stand-in: a seeded Galois LFSR is folded into an 8-bit response.
// Latency: puf_valid pulses EVAL_CYCLES+1 cycles after the accepting edge.
// Backpressure: puf_w is ignored while puf_busy=1; requests are never queued.
module util_puf_emulator #(
    parameter logic [31:0] SEED        = 32'hA5C31E77,
    parameter int          EVAL_CYCLES = 16
) (
    input  logic       aclk,
    input  logic       arstn,
    input  logic [7:0] puf_sela,
    input  logic [7:0] puf_selb,
    input  logic       puf_w,
    output logic [7:0] puf_data,
    output logic       puf_valid,
    output logic       puf_busy
);
    localparam logic [31:0] TAPS     = 32'h80200003;
    localparam logic [15:0] CNT_INIT = 16'(EVAL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t      state;
    logic [31:0] lfsr;
    logic [7:0]  acc;
    logic [15:0] cnt;
    logic [7:0]  sela_q;
    logic [7:0]  selb_q;

    logic [31:0] seed_mix;
    logic [31:0] seed_load;
    logic [31:0] lfsr_next;
    logic [7:0]  acc_next;

    // An all-zero LFSR would lock up, so that one mix value is remapped to 1.
    assign seed_mix  = SEED ^ {puf_sela, puf_selb, ~puf_sela, ~puf_selb};
    assign seed_load = (seed_mix == 32'h0) ? 32'h1 : seed_mix;
    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    assign acc_next  = {acc[6:0], acc[7]} ^ lfsr_next[7:0];

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state     <= IDLE;
            lfsr      <= 32'h0;
            acc       <= 8'h00;
            cnt       <= 16'h0;
            sela_q    <= 8'h00;
            selb_q    <= 8'h00;
            puf_data  <= 8'h00;
            puf_valid <= 1'b0;
            puf_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    puf_valid <= 1'b0;
                    if (puf_w) begin
                        sela_q   <= puf_sela;
                        selb_q   <= puf_selb;
                        acc      <= 8'h00;
                        cnt      <= CNT_INIT;
                        lfsr     <= seed_load;
                        puf_busy <= 1'b1;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    lfsr <= lfsr_next;
                    acc  <= acc_next;
                    cnt  <= cnt - 16'h1;
                    if (cnt == 16'h0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    puf_data  <= (sela_q == selb_q) ? 8'h00 : acc;
                    puf_valid <= 1'b1;
                    puf_busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    puf_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
